// File: rtl/riscv_cache_req_arb.sv
// rtl/riscv_cache_req_arb.sv - round-robin request arbiter in front of the cache tag stage (optional CACHE_ARB_LOCK_TIMEOUT_EN)
`timescale 1ns/1ps
module riscv_cache_req_arb #(
    parameter int XLEN         = 32,
    parameter int PLEN         = XLEN,
    parameter int REQUESTERS   = 2,
    parameter int LOCK_TIMEOUT = 15,
    parameter int SIZE_W       = 3,
    parameter int PROT_W       = 3,
    localparam int IDW         = $clog2(REQUESTERS)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                stall_i,
    input  logic                                flush_i,
    input  logic [REQUESTERS-1:0]               req_i,
    input  logic [REQUESTERS-1:0][PLEN-1:0]     adr_i,
    input  logic [REQUESTERS-1:0][SIZE_W-1:0]   size_i,
    input  logic [REQUESTERS-1:0]               lock_i,
    input  logic [REQUESTERS-1:0][PROT_W-1:0]   prot_i,
    input  logic [REQUESTERS-1:0]               we_i,
    input  logic [REQUESTERS-1:0][XLEN-1:0]     d_i,
    input  logic [REQUESTERS-1:0]               pagefault_i,
    output logic [REQUESTERS-1:0]               ack_o,
    output logic                                req_o,
    output logic [PLEN-1:0]                     phys_adr_o,
    output logic [SIZE_W-1:0]                   size_o,
    output logic                                lock_o,
    output logic [PROT_W-1:0]                   prot_o,
    output logic                                we_o,
    output logic [XLEN-1:0]                     d_o,
    output logic                                pagefault_o,
    output logic [IDW-1:0]                      gnt_id_o
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] last_gnt;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] sel;
    logic           accept;

`ifdef CACHE_ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    logic [CW-1:0] idle_cnt;
`endif

    // Select a client: owner while locked, otherwise round-robin from last_gnt+1
    always_comb begin
        int idx;
        logic found;
        sel   = last_gnt;
        found = 1'b0;
        idx   = 0;
        if (state == ST_LOCK) begin
            sel = owner;
        end else begin
            for (int i = 1; i <= REQUESTERS; i++) begin
                idx = int'(last_gnt) + i;
                if (idx >= REQUESTERS) idx = idx - REQUESTERS;
                if (!found && req_i[idx]) begin
                    sel   = IDW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Request, handshake and field mux toward the tag stage
    always_comb begin
        if (flush_i)
            req_o = 1'b0;
        else if (state == ST_LOCK)
            req_o = req_i[owner];
        else
            req_o = |req_i;
        // Nothing is accepted while the reset is being applied
        accept       = req_o & ~stall_i & ~rst_i;
        ack_o        = '0;
        ack_o[sel]   = accept;
        phys_adr_o   = adr_i[sel];
        size_o       = size_i[sel];
        lock_o       = lock_i[sel];
        prot_o       = prot_i[sel];
        we_o         = we_i[sel];
        d_o          = d_i[sel];
        pagefault_o  = pagefault_i[sel];
        // The id only tags a live request; idle cycles report client 0
        gnt_id_o     = req_o ? sel : '0;
    end

    // Arbitration state: round-robin pointer, lock ownership, flush recovery
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_ARB;
            last_gnt <= IDW'(REQUESTERS - 1);
            owner    <= '0;
        end else if (flush_i) begin
            state <= ST_ARB;
        end else if (accept) begin
            last_gnt <= sel;
            if (lock_i[sel]) begin
                state <= ST_LOCK;
                owner <= sel;
            end else begin
                state <= ST_ARB;
            end
        end
`ifdef CACHE_ARB_LOCK_TIMEOUT_EN
        else if (state == ST_LOCK && !req_i[owner] && idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
            state <= ST_ARB;
        end
`endif
    end

`ifdef CACHE_ARB_LOCK_TIMEOUT_EN
    // Count idle owner cycles in LOCK; the final count forces a release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_cnt <= '0;
        end else if (flush_i || state != ST_LOCK || req_i[owner]) begin
            idle_cnt <= '0;
        end else if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_cache_req_arb.sv
// tb/tb_riscv_cache_req_arb.sv - directed self-checking bench for riscv_cache_req_arb
`timescale 1ns/1ps
module tb_riscv_cache_req_arb;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    // two-client instance
    logic             stall_i, flush_i;
    logic [1:0]       req_i, lock_i, we_i, pagefault_i;
    logic [1:0][31:0] adr_i, d_i;
    logic [1:0][2:0]  size_i, prot_i;
    logic [1:0]       ack_o;
    logic             req_o, lock_o, we_o, pagefault_o;
    logic [31:0]      phys_adr_o, d_o;
    logic [2:0]       size_o, prot_o;
    logic [0:0]       gnt_id_o;

    // three-client instance
    logic [2:0]       req3, lock3, we3, pf3;
    logic [2:0][31:0] adr3, d3;
    logic [2:0][2:0]  size3, prot3;
    logic [2:0]       ack3;
    logic             req3_o, lock3_o, we3_o, pf3_o;
    logic [31:0]      adr3_o, d3_o;
    logic [2:0]       size3_o, prot3_o;
    logic [1:0]       gnt3_o;

    int n_cmp  = 0;
    int n_fail = 0;

    riscv_cache_req_arb #(.XLEN(32), .REQUESTERS(2)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .req_i(req_i), .adr_i(adr_i), .size_i(size_i), .lock_i(lock_i),
        .prot_i(prot_i), .we_i(we_i), .d_i(d_i), .pagefault_i(pagefault_i),
        .ack_o(ack_o), .req_o(req_o), .phys_adr_o(phys_adr_o), .size_o(size_o),
        .lock_o(lock_o), .prot_o(prot_o), .we_o(we_o), .d_o(d_o),
        .pagefault_o(pagefault_o), .gnt_id_o(gnt_id_o)
    );

    riscv_cache_req_arb #(.XLEN(32), .REQUESTERS(3)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(1'b0), .flush_i(1'b0),
        .req_i(req3), .adr_i(adr3), .size_i(size3), .lock_i(lock3),
        .prot_i(prot3), .we_i(we3), .d_i(d3), .pagefault_i(pf3),
        .ack_o(ack3), .req_o(req3_o), .phys_adr_o(adr3_o), .size_o(size3_o),
        .lock_o(lock3_o), .prot_o(prot3_o), .we_o(we3_o), .d_o(d3_o),
        .pagefault_o(pf3_o), .gnt_id_o(gnt3_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // settle combinational outputs mid-cycle
    task automatic settle();
        #1;
    endtask

    // advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ack, req and gnt of the two-client instance, plus muxed address/data of the grantee
    task automatic chk2(input string tag, input logic [1:0] e_ack, input logic e_req, input logic e_gnt);
        settle();
        check({tag, ".ack"}, 64'(ack_o), 64'(e_ack));
        check({tag, ".req"}, 64'(req_o), 64'(e_req));
        check({tag, ".gnt"}, 64'(gnt_id_o), 64'(e_gnt));
        if (e_req) begin
            check({tag, ".adr"}, 64'(phys_adr_o), 64'(32'h1000_0000 + 32'(e_gnt) * 32'h10));
            check({tag, ".d"}, 64'(d_o), 64'(32'hD000 + 32'(e_gnt)));
        end
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        req_i = '0; lock_i = '0; we_i = 2'b10; pagefault_i = 2'b01;
        req3 = '0; lock3 = '0; we3 = '0; pf3 = '0;
        for (int k = 0; k < 2; k++) begin
            adr_i[k] = 32'h1000_0000 + 32'(k) * 32'h10;
            d_i[k]   = 32'hD000 + 32'(k);
            size_i[k] = 3'(k + 1);
            prot_i[k] = 3'(k + 4);
        end
        for (int k = 0; k < 3; k++) begin
            adr3[k] = 32'h2000_0000 + 32'(k);
            d3[k]   = 32'(k);
            size3[k] = 3'(k);
            prot3[k] = 3'(k);
        end
        tick(); tick();
        chk2("reset", 2'b00, 1'b0, 1'b0);
        rst_i = 1'b0;
        tick();
        chk2("idle", 2'b00, 1'b0, 1'b0);

        // 1: constant dual request alternates
        req_i = 2'b11;
        chk2("rr0", 2'b01, 1'b1, 1'b0);
        check("rr0.size", 64'(size_o), 64'd1);
        check("rr0.we", 64'(we_o), 64'd0);
        check("rr0.pf", 64'(pagefault_o), 64'd1);
        tick(); chk2("rr1", 2'b10, 1'b1, 1'b1);
        check("rr1.prot", 64'(prot_o), 64'd5);
        check("rr1.we", 64'(we_o), 64'd1);
        tick(); chk2("rr2", 2'b01, 1'b1, 1'b0);
        tick(); chk2("rr3", 2'b10, 1'b1, 1'b1);
        tick();

        // 2: stall holds pointer
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk2($sformatf("stall%0d", i), 2'b00, 1'b1, 1'b0);
            tick();
        end
        stall_i = 1'b0;
        chk2("stall_rel", 2'b01, 1'b1, 1'b0);
        tick();

        // 3: locked sequence of client 1 while client 0 keeps requesting
        lock_i = 2'b10;
        chk2("lk0", 2'b10, 1'b1, 1'b1);
        check("lk0.lock", 64'(lock_o), 64'd1);
        tick(); chk2("lk1", 2'b10, 1'b1, 1'b1);
        tick(); chk2("lk2", 2'b10, 1'b1, 1'b1);
        tick(); lock_i = 2'b00;
        chk2("lk3", 2'b10, 1'b1, 1'b1);
        tick(); chk2("lk_end", 2'b01, 1'b1, 1'b0);
        tick();

        // 4: flush inside LOCK
        lock_i = 2'b10;
        chk2("fl_lock", 2'b10, 1'b1, 1'b1);
        tick();
        flush_i = 1'b1;
        chk2("fl", 2'b00, 1'b0, 1'b0);
        tick();
        flush_i = 1'b0;
        chk2("fl_after", 2'b01, 1'b1, 1'b0);
        tick();

        // 5: owner goes idle inside LOCK while client 0 waits
        chk2("to_lock", 2'b10, 1'b1, 1'b1);
        tick();
        req_i = 2'b01; lock_i = 2'b00;
        for (int i = 1; i <= 16; i++) begin
            settle();
`ifdef CACHE_ARB_LOCK_TIMEOUT_EN
            check($sformatf("to_c%0d", i), 64'(ack_o), (i == 16) ? 64'd1 : 64'd0);
`else
            check($sformatf("to_c%0d", i), 64'(ack_o), 64'd0);
`endif
            tick();
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;

        // reset in the middle of a locked sequence
        req_i = 2'b11; lock_i = 2'b10;
        settle();
        tick();
        req_i = 2'b11; lock_i = 2'b10;
        rst_i = 1'b1;
        chk2("rst_mid", 2'b00, 1'b1, 1'b0);
        tick();
        rst_i = 1'b0; lock_i = 2'b00;
        chk2("rst_after", 2'b01, 1'b1, 1'b0);
        req_i = 2'b00;
        tick();

        // 6: three clients, wrap-around
        req3 = 3'b001;
        settle(); check("r3_first", 64'(ack3), 64'b001);
        tick();
        req3 = 3'b101;
        settle(); check("r3_c2", 64'(ack3), 64'b100);
        check("r3_c2.gnt", 64'(gnt3_o), 64'd2);
        check("r3_c2.adr", 64'(adr3_o), 64'h2000_0002);
        tick();
        settle(); check("r3_wrap", 64'(ack3), 64'b001);
        check("r3_wrap.gnt", 64'(gnt3_o), 64'd0);
        tick();
        req3 = 3'b010;
        settle(); check("r3_c1", 64'(ack3), 64'b010);
        tick();
        req3 = 3'b000;
        settle(); check("r3_idle", 64'(req3_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
